// File: rtl/rr_req_agent_pkg.sv
// Shared types and defaults for the round-robin request agent.
// Also holds the common one-hot to index encoder.
package rr_req_agent_pkg;

    localparam int W_DEF        = 4;
    localparam int DEPTH_DEF    = 2;
    localparam int STARVE_N_DEF = 16;
    localparam int ENC_MAX      = 32;
    localparam int ENC_W        = $clog2(ENC_MAX);

    typedef logic [$clog2(W_DEF)-1:0] lane_idx_t;

    // One-hot (or zero) vector to binary index.
    function automatic logic [ENC_W-1:0] onehot_enc(
        input logic [ENC_MAX-1:0] oh
    );
        logic [ENC_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < ENC_MAX; i++) begin
            if (oh[i]) idx = idx | ENC_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_req_agent_q.sv
// Per-lane FIFO queue for the request agent.
// No bypass: a pop frees its slot only from the next cycle.
module rr_req_agent_q #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [DATA_W-1:0] head_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_q, wr_d;
    logic [AW-1:0]     rd_q, rd_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              push_ok;
    logic              pop_ok;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_q];
    assign push_ok = push_i & !full_o;
    assign pop_ok  = pop_i & !empty_o;

    // Next pointers and occupancy; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_d  = wr_q + AW'(push_ok);
        rd_d  = rd_q + AW'(pop_ok);
        cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
    end

    // Pointer and count state.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage array; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/rr_req_agent.sv
// Round-robin request agent: per-lane queues feeding an
// external arbiter, with grant checking and starvation flags.
module rr_req_agent
    import rr_req_agent_pkg::*;
#(
    parameter int W        = W_DEF,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int STARVE_N = STARVE_N_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [W-1:0]          i_in_vld,
    input  logic [W*DATA_W-1:0]   i_in_data,
    output logic [W-1:0]          o_in_rdy,
    output logic [W-1:0]          o_req,
    input  logic [W-1:0]          i_gnt,
    output logic                  o_ack,
    output logic                  o_out_vld,
    output logic [DATA_W-1:0]     o_out_data,
    output logic [$clog2(W)-1:0]  o_out_lane,
    input  logic                  i_out_rdy,
    output logic [W-1:0]          o_starve,
    output logic                  o_err
);

    localparam int LW = $clog2(W);
    localparam int SW = $clog2(STARVE_N + 1);

    logic [W-1:0]      full;
    logic [W-1:0]      empty;
    logic [W-1:0]      pop;
    logic [DATA_W-1:0] head [W];

    logic              out_free;
    logic              gnt_any;
    logic              gnt_onehot;
    logic              grant_legal;
    logic [LW-1:0]     gnt_idx;

    logic              vld_q, vld_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [LW-1:0]     lane_q, lane_d;
    logic              err_q, err_d;
    logic [SW-1:0]     stv_q [W];
    logic [SW-1:0]     stv_d [W];

    for (genvar i = 0; i < W; i++) begin : g_lane
        rr_req_agent_q #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_q (
            .clk     (clk),
            .rst     (rst),
            .push_i  (i_in_vld[i]),
            .data_i  (i_in_data[i*DATA_W +: DATA_W]),
            .pop_i   (pop[i]),
            .full_o  (full[i]),
            .empty_o (empty[i]),
            .head_o  (head[i])
        );
        assign o_in_rdy[i] = !full[i];
        assign o_req[i]    = !empty[i];
        assign o_starve[i] = (stv_q[i] == SW'(STARVE_N));
    end

    assign out_free    = !vld_q | i_out_rdy;
    assign gnt_any     = (i_gnt != '0);
    assign gnt_onehot  = gnt_any & ((i_gnt & (i_gnt - 1'b1)) == '0);
    assign grant_legal = gnt_onehot & ((i_gnt & ~o_req) == '0);
    assign o_ack       = gnt_any & out_free & grant_legal & !rst;
    assign pop         = o_ack ? i_gnt : '0;
    assign gnt_idx     = LW'(onehot_enc(ENC_MAX'(i_gnt)));

    assign o_out_vld  = vld_q;
    assign o_out_data = data_q;
    assign o_out_lane = lane_q;
    assign o_err      = err_q;

    // Output register: load on ack, drain when free, else hold.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        lane_d = lane_q;
        err_d  = err_q | (gnt_any & !grant_legal);
        if (o_ack) begin
            vld_d  = 1'b1;
            data_d = head[gnt_idx];
            lane_d = gnt_idx;
        end else if (out_free) begin
            vld_d  = 1'b0;
        end
    end

    // Starvation counters: count waiting cycles, saturate.
    always_comb begin
        for (int i = 0; i < W; i++) begin
            stv_d[i] = stv_q[i];
            if (pop[i] || !o_req[i]) begin
                stv_d[i] = '0;
            end else if (stv_q[i] != SW'(STARVE_N)) begin
                stv_d[i] = stv_q[i] + 1'b1;
            end
        end
    end

    // Output, error and starvation state.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            lane_q <= '0;
            err_q  <= 1'b0;
            for (int i = 0; i < W; i++) stv_q[i] <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            lane_q <= lane_d;
            err_q  <= err_d;
            for (int i = 0; i < W; i++) stv_q[i] <= stv_d[i];
        end
    end

endmodule

// File: tb/tb_rr_req_agent.sv
// Directed self-checking bench for rr_req_agent.
// Default parameters: W=4, DATA_W=32, DEPTH=2, STARVE_N=16.
module tb_rr_req_agent;

    logic         clk;
    logic         rst;
    logic [3:0]   in_vld;
    logic [127:0] in_data;
    logic [3:0]   in_rdy;
    logic [3:0]   req;
    logic [3:0]   gnt;
    logic         ack;
    logic         out_vld;
    logic [31:0]  out_data;
    logic [1:0]   out_lane;
    logic         out_rdy;
    logic [3:0]   starve;
    logic         err;

    int n_chk;
    int n_err;

    rr_req_agent dut (
        .clk        (clk),
        .rst        (rst),
        .i_in_vld   (in_vld),
        .i_in_data  (in_data),
        .o_in_rdy   (in_rdy),
        .o_req      (req),
        .i_gnt      (gnt),
        .o_ack      (ack),
        .o_out_vld  (out_vld),
        .o_out_data (out_data),
        .o_out_lane (out_lane),
        .i_out_rdy  (out_rdy),
        .o_starve   (starve),
        .o_err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int lane, input logic [31:0] v);
        in_data[lane*32 +: 32] = v;
    endtask

    initial begin
        n_chk   = 0;
        n_err   = 0;
        rst     = 1'b1;
        in_vld  = '0;
        in_data = '0;
        gnt     = '0;
        out_rdy = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_vld", 32'(out_vld), 32'h0);
        chk("rst_data", out_data, 32'h0);
        chk("rst_lane", 32'(out_lane), 32'h0);
        chk("rst_req", 32'(req), 32'h0);
        chk("rst_rdy", 32'(in_rdy), 32'hF);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_starve", 32'(starve), 32'h0);
        chk("rst_ack", 32'(ack), 32'h0);

        // single push on lane 2
        put(2, 32'hA5A5_0002);
        in_vld = 4'b0100;
        tick();
        in_vld = '0;
        chk("s_req", 32'(req), 32'h4);
        chk("s_vld0", 32'(out_vld), 32'h0);
        gnt = 4'b0100;
        #1;
        chk("s_ack", 32'(ack), 32'h1);
        tick();
        gnt = '0;
        #1;
        chk("s_vld", 32'(out_vld), 32'h1);
        chk("s_data", out_data, 32'hA5A5_0002);
        chk("s_lane", 32'(out_lane), 32'h2);
        chk("s_ack_once", 32'(ack), 32'h0);
        chk("s_req_clr", 32'(req), 32'h0);
        tick();
        chk("s_drain", 32'(out_vld), 32'h0);

        // fill and drain lane 0
        put(0, 32'h1000_0000);
        in_vld = 4'b0001;
        tick();
        chk("f_rdy1", 32'(in_rdy[0]), 32'h1);
        put(0, 32'h1000_0001);
        tick();
        chk("f_full", 32'(in_rdy[0]), 32'h0);
        put(0, 32'h1000_0002);
        gnt = 4'b0001;
        #1;
        chk("f_ack0", 32'(ack), 32'h1);
        tick();
        chk("f_d0", out_data, 32'h1000_0000);
        chk("f_rdy_back", 32'(in_rdy[0]), 32'h1);
        tick();
        in_vld = '0;
        #1;
        chk("f_d1", out_data, 32'h1000_0001);
        chk("f_req1", 32'(req), 32'h1);
        tick();
        gnt = '0;
        #1;
        chk("f_d2", out_data, 32'h1000_0002);
        chk("f_vld2", 32'(out_vld), 32'h1);
        chk("f_empty", 32'(req), 32'h0);
        tick();
        chk("f_end", 32'(out_vld), 32'h0);

        // backpressure
        put(0, 32'hB000_0000);
        in_vld = 4'b0001;
        tick();
        put(0, 32'hB000_0001);
        tick();
        in_vld = '0;
        gnt = 4'b0001;
        tick();
        chk("b_d0", out_data, 32'hB000_0000);
        out_rdy = 1'b0;
        #1;
        chk("b_ack0", 32'(ack), 32'h0);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("b_hold", out_data, 32'hB000_0000);
            chk("b_vld", 32'(out_vld), 32'h1);
            chk("b_req", 32'(req), 32'h1);
            chk("b_ack", 32'(ack), 32'h0);
        end
        out_rdy = 1'b1;
        #1;
        chk("b_ack_rel", 32'(ack), 32'h1);
        tick();
        gnt = '0;
        #1;
        chk("b_d1", out_data, 32'hB000_0001);
        tick();
        chk("b_end", 32'(out_vld), 32'h0);

        // illegal grants
        put(0, 32'hC000_0000);
        in_vld = 4'b0001;
        tick();
        in_vld = '0;
        gnt = 4'b0011;
        #1;
        chk("e_ack_multi", 32'(ack), 32'h0);
        tick();
        chk("e_err1", 32'(err), 32'h1);
        chk("e_req1", 32'(req), 32'h1);
        chk("e_rdy1", 32'(in_rdy), 32'hF);
        chk("e_vld1", 32'(out_vld), 32'h0);
        gnt = 4'b1000;
        #1;
        chk("e_ack_noreq", 32'(ack), 32'h0);
        tick();
        chk("e_err2", 32'(err), 32'h1);
        chk("e_req2", 32'(req), 32'h1);
        gnt = 4'b0001;
        tick();
        gnt = '0;
        #1;
        chk("e_drain", out_data, 32'hC000_0000);
        chk("e_sticky", 32'(err), 32'h1);
        tick();

        // starvation on lane 1
        put(1, 32'hD000_0001);
        in_vld = 4'b0010;
        tick();
        in_vld = '0;
        for (int k = 0; k < 15; k++) tick();
        chk("st_15", 32'(starve), 32'h0);
        tick();
        chk("st_16", 32'(starve), 32'h2);
        tick();
        chk("st_sat", 32'(starve), 32'h2);
        gnt = 4'b0010;
        tick();
        gnt = '0;
        #1;
        chk("st_clr", 32'(starve), 32'h0);
        chk("st_data", out_data, 32'hD000_0001);
        tick();

        // reset mid-stream
        for (int l = 0; l < 4; l++) put(l, 32'hE000_0000 + 32'(l));
        in_vld = 4'b1111;
        tick();
        tick();
        in_vld = '0;
        #1;
        chk("r_full", 32'(in_rdy), 32'h0);
        gnt = 4'b0001;
        tick();
        chk("r_vld", 32'(out_vld), 32'h1);
        chk("r_data", out_data, 32'hE000_0000);
        rst = 1'b1;
        #1;
        chk("r_ack_rst", 32'(ack), 32'h0);
        tick();
        rst = 1'b0;
        gnt = '0;
        #1;
        chk("r_vld0", 32'(out_vld), 32'h0);
        chk("r_req0", 32'(req), 32'h0);
        chk("r_rdy", 32'(in_rdy), 32'hF);
        chk("r_err0", 32'(err), 32'h0);
        chk("r_data0", out_data, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
